// File: rtl/rr_arbiter_binary_pkg.sv
// rr_arbiter_binary_pkg: shared state type and pointer wrap helper for the round-robin arbiter
package rr_arbiter_binary_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned count);
    return (idx == count - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotated priority search, first set req bit at or after ptr with wrap
module rr_priority_pick #(
  parameter int REQ_COUNT = 4,
  parameter int SEL_WIDTH = $clog2(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [SEL_WIDTH-1:0] idx
);
  logic [REQ_COUNT-1:0] rot;
  logic [SEL_WIDTH-1:0] off;
  logic [SEL_WIDTH:0]   sum;
  always_comb begin
    rot = REQ_COUNT'({req, req} >> ptr);
    off = '0;
    for (int i = REQ_COUNT - 1; i >= 0; i--) if (rot[i]) off = SEL_WIDTH'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    found = |req;
    // explicit compare keeps non-power-of-two counts from producing out-of-range indices
    idx = (sum >= (SEL_WIDTH+1)'(REQ_COUNT)) ? SEL_WIDTH'(sum - (SEL_WIDTH+1)'(REQ_COUNT)) : sum[SEL_WIDTH-1:0];
  end
endmodule

// File: rtl/rr_arbiter_binary.sv
// rr_arbiter_binary: round-robin arbiter with registered binary grant and valid/ready handshake.
// Optional packet lock (gnt_lock port) enabled with `define ARB_LOCK_EN.
module rr_arbiter_binary
  import rr_arbiter_binary_pkg::*;
#(
  parameter  int REQ_COUNT = 4,
  localparam int SEL_WIDTH = $clog2(REQ_COUNT)
) (
  input  logic                 reset_n,
  input  logic                 clk,
  input  logic [REQ_COUNT-1:0] req,
  output logic [SEL_WIDTH-1:0] gnt_bin,
  output logic                 gnt_valid,
  input  logic                 gnt_ready
`ifdef ARB_LOCK_EN
  ,
  input  logic                 gnt_lock
`endif
);
  arb_state_t state;
  logic [SEL_WIDTH-1:0] ptr, next_ptr, pick_ptr, pick_idx;
  logic pick_found, hs, lock_hold;
  always_comb begin
    hs = (state == GRANT) && gnt_ready;
    next_ptr = SEL_WIDTH'(rr_wrap_inc(32'(gnt_bin), REQ_COUNT));
    pick_ptr = (state == GRANT) ? next_ptr : ptr;
`ifdef ARB_LOCK_EN
    lock_hold = hs && gnt_lock && req[gnt_bin];
`else
    lock_hold = 1'b0;
`endif
  end
  rr_priority_pick #(.REQ_COUNT(REQ_COUNT), .SEL_WIDTH(SEL_WIDTH)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_bin   <= '0;
      ptr       <= '0;
    end else if (state == IDLE) begin
      if (pick_found) begin
        gnt_bin   <= pick_idx;
        gnt_valid <= 1'b1;
        state     <= GRANT;
      end
    end else if (hs && !lock_hold) begin
      ptr <= next_ptr;
      if (pick_found) gnt_bin <= pick_idx;
      else begin
        gnt_valid <= 1'b0;
        state     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter_binary.sv
// tb_rr_arbiter_binary: directed and random checks of 4- and 5-requester arbiters against a queue-free reference model
module tb_rr_arbiter_binary;
  logic clk = 1'b0, reset_n = 1'b0, gnt_ready = 1'b0, gnt_ready5 = 1'b0, gnt_lock = 1'b0;
  logic [3:0] req = '0;
  logic [4:0] req5 = '0;
  logic [1:0] gnt_bin;
  logic [2:0] gnt_bin5;
  logic gnt_valid, gnt_valid5, gnt_lock5;
  int n_checks = 0, n_pass = 0;
  int m_v[2], m_g[2], m_p[2];
`ifdef ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  assign gnt_lock5 = 1'b0;
  always #5 clk = ~clk;
  rr_arbiter_binary #(.REQ_COUNT(4)) u4 (
    .reset_n(reset_n), .clk(clk), .req(req), .gnt_bin(gnt_bin),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready)
`ifdef ARB_LOCK_EN
    , .gnt_lock(gnt_lock)
`endif
  );
  rr_arbiter_binary #(.REQ_COUNT(5)) u5 (
    .reset_n(reset_n), .clk(clk), .req(req5), .gnt_bin(gnt_bin5),
    .gnt_valid(gnt_valid5), .gnt_ready(gnt_ready5)
`ifdef ARB_LOCK_EN
    , .gnt_lock(gnt_lock5)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  function automatic int first_from(input int n, input int p, input logic [7:0] r);
    for (int k = 0; k < n; k++) if (r[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction
  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 0; m_g[d] = 0; m_p[d] = 0;
    end
  endtask
  task automatic mstep(input int d, input int n, input logic [7:0] r, input logic rdy, input logic lk);
    int w;
    if (m_v[d] == 0) begin
      w = first_from(n, m_p[d], r);
      if (w >= 0) begin m_g[d] = w; m_v[d] = 1; end
    end else if (rdy && !(lk && r[m_g[d]])) begin
      m_p[d] = (m_g[d] + 1) % n;
      w = first_from(n, m_p[d], r);
      if (w >= 0) m_g[d] = w;
      else m_v[d] = 0;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (reset_n) begin
      mstep(0, 4, {4'b0, req}, gnt_ready, LOCK & gnt_lock);
      mstep(1, 5, {3'b0, req5}, gnt_ready5, 1'b0);
    end else mreset();
    #1;
    chk("valid4", gnt_valid, m_v[0]);
    if (m_v[0] != 0) chk("bin4", gnt_bin, m_g[0]);
    chk("valid5", gnt_valid5, m_v[1]);
    if (m_v[1] != 0) chk("bin5", gnt_bin5, m_g[1]);
    if (gnt_valid5) chk("range5", gnt_bin5 < 3'd5, 1);
  endtask
  initial begin
    int rot_exp[4] = '{1, 2, 3, 0};
    mreset();
    req = 4'b1111;
    cyc(); cyc();
    chk("rst_valid", gnt_valid, 0);
    chk("rst_bin", gnt_bin, 0);
    reset_n = 1'b1;
    cyc();
    chk("rel_valid", gnt_valid, 1);
    chk("rel_bin", gnt_bin, 0);
    gnt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rot_bin", gnt_bin, rot_exp[i]);
      chk("rot_valid", gnt_valid, 1);
    end
    req = 4'b0000;
    cyc();
    chk("drain_valid", gnt_valid, 0);
    req = 4'b0100; gnt_ready = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) req = 4'b0000;
      cyc();
      chk("bp_bin", gnt_bin, 2);
      chk("bp_valid", gnt_valid, 1);
    end
    gnt_ready = 1'b1;
    cyc();
    chk("bp_done", gnt_valid, 0);
    gnt_ready = 1'b0; req = 4'b1000;
    cyc();
    chk("pre_async_bin", gnt_bin, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", gnt_valid, 0);
    chk("async_bin", gnt_bin, 0);
    mreset();
    reset_n = 1'b1;
    cyc();
    chk("post_async_bin", gnt_bin, 3);
    chk("post_async_valid", gnt_valid, 1);
    req5 = 5'b01000;
    cyc();
    chk("sparse_first", gnt_bin5, 3);
    req5 = 5'b00001; gnt_ready5 = 1'b1;
    cyc();
    chk("sparse_wrap", gnt_bin5, 0);
`ifdef ARB_LOCK_EN
    #2 reset_n = 1'b0;
    #1 mreset();
    reset_n = 1'b1;
    req = 4'b0011; gnt_ready = 1'b1; gnt_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("lock_bin", gnt_bin, 0);
    end
    gnt_lock = 1'b0;
    cyc();
    chk("unlock_bin", gnt_bin, 1);
`endif
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom);
      req5 = 5'($urandom);
      gnt_ready = ($urandom_range(0, 3) != 0);
      gnt_ready5 = ($urandom_range(0, 2) != 0);
      gnt_lock = ($urandom_range(0, 3) == 0);
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
